fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, PC and memory address width.
REQ-002 Parameter DATA_WIDTH, default 32, instruction width.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 Parameter DEPTH, default 2, fetch-queue entries and maximum requests in flight; a power of two, at least 2.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 PCSrc  in  1  redirect: a taken branch or jump from the control unit.
REQ-008 PCTarget  in  ADDR_WIDTH  redirect target address.
REQ-009 StallF  in  1  downstream not accepting the presented instruction.
REQ-010 imem_req_valid  out  1, imem_req_addr  out  ADDR_WIDTH, imem_req_ready  in  1  request channel; transfer occurs when valid and ready are both high.
REQ-011 imem_rsp_valid  in  1, imem_rsp_data  in  DATA_WIDTH  in-order response channel, always accepted.
REQ-012 InstrValidF  out  1, InstrF  out  DATA_WIDTH, PCF  out  ADDR_WIDTH, PCPlus4F  out  ADDR_WIDTH  presented instruction.
REQ-013 MisalignF  out  1  sticky misaligned-redirect flag.

Function
REQ-014 FSM states: IDLE, RUN, HALT; reset enters IDLE; IDLE goes to RUN unconditionally after one cycle; HALT is exited only by reset.
REQ-015 The queue is circular with DEPTH entries, each holding pc, instr and a filled bit; read/write pointers wrap modulo DEPTH.
REQ-016 imem_req_valid is 1 only when: state is RUN, PCSrc is 0, and (allocated entries + drop_cnt) < DEPTH.
REQ-017 imem_req_addr = next_pc.
REQ-018 On a request transfer: allocate the tail entry with pc = next_pc and filled = 0, then set next_pc to next_pc + 4.
REQ-019 When imem_rsp_valid = 1 and drop_cnt > 0: discard the response and decrement drop_cnt.
REQ-020 Otherwise a response fills the oldest unfilled entry. A response with no unfilled entry is ignored.
REQ-021 InstrValidF = head entry allocated and filled. InstrF and PCF come from the head entry. PCPlus4F = PCF + 4, modulo 2^ADDR_WIDTH.
REQ-022 The head pops when InstrValidF = 1, StallF = 0 and PCSrc = 0.
REQ-023 Best-case latency: request transfer in cycle N, response in cycle N+1, InstrValidF high in cycle N+2.
REQ-024 Redirect (PCSrc = 1), effective at the clock edge:
  - empty the queue;
  - drop_cnt <= (drop_cnt + allocated-unfilled entries) minus 1 if a live, non-dropped response arrives in the same cycle;
  - next_pc <= PCTarget;
  - no request issues and no pop occurs in that cycle.
REQ-025 Back-to-back redirects are legal; the last one wins, and drop_cnt accumulates per REQ-024.
REQ-026 Simultaneous pop and fill of the same entry is not possible; simultaneous push and pop are both performed.
REQ-027 next_pc wraps modulo 2^ADDR_WIDTH.

Reset
REQ-028 While rst_n = 0 at a clock edge, the block is reset to:
  - state IDLE, next_pc = RESET_PC, queue empty, drop_cnt = 0;
  - imem_req_valid = 0, InstrValidF = 0, MisalignF = 0;
  - InstrF = 0, PCF = RESET_PC, PCPlus4F = RESET_PC + 4.
REQ-029 Reset asserted mid-operation abandons all in-flight requests; responses arriving after reset release are not dropped and are ignored if no entry is allocated.

Configuration
REQ-030 FETCH_ALIGN_CHECK_EN defined: a redirect with PCTarget[1:0] != 0 sets MisalignF = 1 and moves the FSM to HALT (no further requests). The queue is flushed, and drop handling proceeds per REQ-024.
REQ-031 FETCH_ALIGN_CHECK_EN undefined: PCTarget[1:0] is treated as 0, MisalignF is tied to 0, and HALT is unreachable.

Verification
REQ-032 Reset, then zero-wait memory returning 0x00000013 every cycle, StallF = 0 -> first InstrValidF in cycle 3 after release with PCF = 0x0, followed by PCF 0x4, 0x8, ... one per cycle.
REQ-033 StallF held high 5 cycles with DEPTH = 2 -> at most 2 request transfers, then imem_req_valid = 0; PCF is stable. On release, the entries drain in order without loss.
REQ-034 PCSrc = 1 with PCTarget = 0x100 while 2 requests are outstanding -> the next 2 responses are discarded, the next imem_req_addr is 0x100, and the first post-redirect PCF is 0x100.
REQ-035 imem_req_ready held low 4 cycles -> imem_req_valid stays high and imem_req_addr stays stable; no InstrValidF occurs until a transfer and response complete.
REQ-036 With FETCH_ALIGN_CHECK_EN, PCSrc = 1 with PCTarget = 0x102 -> MisalignF = 1 the next cycle and stays high, no further requests are issued, and InstrValidF = 0. Without the macro, the next fetch address is 0x100.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, circular fetch queue and drop accounting for redirects.
// Optional build macro FETCH_ALIGN_CHECK_EN: a misaligned redirect target sets MisalignF and halts fetch.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PCSrc,
  input  logic [ADDR_WIDTH-1:0] PCTarget,
  input  logic                  StallF,
  output logic                  imem_req_valid,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  InstrValidF,
  output logic [DATA_WIDTH-1:0] InstrF,
  output logic [ADDR_WIDTH-1:0] PCF,
  output logic [ADDR_WIDTH-1:0] PCPlus4F,
  output logic                  MisalignF
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [ADDR_WIDTH-1:0] q_pc    [DEPTH];
  logic [DATA_WIDTH-1:0] q_instr [DEPTH];
  logic [DEPTH-1:0]      q_filled;
  logic [PTR_W-1:0]      rd_ptr, wr_ptr, fill_ptr;
  logic [CNT_W-1:0]      alloc_cnt, unfilled_cnt, drop_cnt;
  logic [OCC_W-1:0]      occupancy;
  logic [ADDR_WIDTH-1:0] target_pc;
  logic                  misalign_hit;
  logic                  push, pop, rsp_drop, rsp_fill, rsp_used;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  assign target_pc    = PCTarget;
  assign misalign_hit = PCSrc && (PCTarget[1:0] != 2'b00);
  assign MisalignF    = misalign_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (misalign_hit) begin
      misalign_q <= 1'b1;
    end
  end
`else
  assign target_pc    = PCTarget & ~ADDR_WIDTH'(3);
  assign misalign_hit = 1'b0;
  assign MisalignF    = 1'b0;
`endif

  // Drop budget counts toward occupancy so discarded responses never overrun the queue.
  assign occupancy      = OCC_W'(alloc_cnt) + OCC_W'(drop_cnt);
  assign imem_req_valid = (state == RUN) && !PCSrc && (occupancy < OCC_W'(DEPTH));
  assign imem_req_addr  = next_pc;
  assign push           = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill = imem_rsp_valid && (drop_cnt == '0) && (unfilled_cnt != '0);
  assign rsp_used = rsp_drop || rsp_fill;

  // Responses return in order, so unfilled entries are always the youngest ones in the queue.
  assign fill_ptr = wr_ptr - PTR_W'(unfilled_cnt);

  assign InstrValidF = (alloc_cnt != '0) && q_filled[rd_ptr];
  assign InstrF      = q_instr[rd_ptr];
  assign PCF         = q_pc[rd_ptr];
  assign PCPlus4F    = PCF + ADDR_WIDTH'(4);
  assign pop         = InstrValidF && !StallF && !PCSrc;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = misalign_hit ? HALT : RUN;
      RUN:     if (misalign_hit) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      next_pc      <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      alloc_cnt    <= '0;
      unfilled_cnt <= '0;
      drop_cnt     <= '0;
      q_filled     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]    <= RESET_PC;
        q_instr[i] <= '0;
      end
    end else begin
      state <= state_nxt;

      if (push) begin
        q_pc[wr_ptr]     <= next_pc;
        q_filled[wr_ptr] <= 1'b0;
      end
      if (rsp_fill) begin
        q_instr[fill_ptr]  <= imem_rsp_data;
        q_filled[fill_ptr] <= 1'b1;
      end

      // A redirect flushes the queue; every still-unanswered request becomes a pending drop.
      if (PCSrc) begin
        next_pc      <= target_pc;
        rd_ptr       <= '0;
        wr_ptr       <= '0;
        alloc_cnt    <= '0;
        unfilled_cnt <= '0;
        drop_cnt     <= drop_cnt + unfilled_cnt - CNT_W'(rsp_used);
      end else begin
        if (push) begin
          next_pc <= next_pc + ADDR_WIDTH'(4);
          wr_ptr  <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        alloc_cnt    <= alloc_cnt + CNT_W'(push) - CNT_W'(pop);
        unfilled_cnt <= unfilled_cnt + CNT_W'(push) - CNT_W'(rsp_fill);
        if (rsp_drop) begin
          drop_cnt <= drop_cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule
